// File: rtl/ser_demux_transmitter.sv
// Serial framer/demultiplexer: start bit, channel address, payload length,
// then routes payload bits to one of 2**CH_BITS serial outputs.
module ser_demux_transmitter #(
    parameter int unsigned CH_BITS    = 2,
    parameter int unsigned LEN_BITS   = 4,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     ser_in,
    output logic [2**CH_BITS-1:0]    ser_out,
    output logic [2**CH_BITS-1:0]    ser_out_valid,
    output logic [LEN_BITS-1:0]      count_out,
    output logic [CH_BITS-1:0]       ch_out,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned FIELD_MAX = (CH_BITS > LEN_BITS) ? CH_BITS : LEN_BITS;
    localparam int unsigned CNT_W     = $clog2(FIELD_MAX) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CH_BITS-1:0]  addr_sr;
    logic [LEN_BITS-1:0] len_sr;
    logic [LEN_BITS-1:0] count;
    logic [CH_BITS-1:0]  ch;

    logic [CH_BITS-1:0]  addr_val;
    logic [LEN_BITS-1:0] len_val;
    logic                addr_last;
    logic                len_last;

    // Shift-register contents including the bit arriving on this edge (MSB first).
    assign addr_val  = CH_BITS'({addr_sr, ser_in});
    assign len_val   = LEN_BITS'({len_sr, ser_in});
    assign addr_last = (bit_cnt == CNT_W'(CH_BITS - 1));
    assign len_last  = (bit_cnt == CNT_W'(LEN_BITS - 1));

    assign count_out = count;
    assign ch_out    = ch;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        busy          = (state != IDLE);
        done          = (state == DONE);
        ser_out       = '0;
        ser_out_valid = '0;
        case (state)
            IDLE: begin
                if (clk_en && (ser_in != IDLE_LEVEL)) begin
                    next_state = ADDR;
                end
            end
            ADDR: begin
                if (clk_en && addr_last) begin
                    next_state = LEN;
                end
            end
            LEN: begin
                if (clk_en && len_last) begin
                    next_state = (len_val == '0) ? DONE : DATA;
                end
            end
            DATA: begin
                ser_out[ch]       = ser_in;
                ser_out_valid[ch] = 1'b1;
                if (clk_en && (count == LEN_BITS'(1))) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            addr_sr <= '0;
            len_sr  <= '0;
            count   <= '0;
            ch      <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                end
                ADDR: begin
                    addr_sr <= addr_val;
                    if (addr_last) begin
                        ch      <= addr_val;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                LEN: begin
                    len_sr <= len_val;
                    if (len_last) begin
                        count   <= len_val;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    count <= count - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ser_demux_transmitter.sv
// Self-checking bench for ser_demux_transmitter: per-cycle expected outputs
// are queued when inputs are driven and compared on the falling edge.
module tb_ser_demux_transmitter;

    logic       clk;
    logic       rst;
    logic       clk_en;
    logic       ser_in;
    logic [3:0] ser_out;
    logic [3:0] ser_out_valid;
    logic [3:0] count_out;
    logic [1:0] ch_out;
    logic       busy;
    logic       done;

    ser_demux_transmitter #(
        .CH_BITS   (2),
        .LEN_BITS  (4),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .ser_in       (ser_in),
        .ser_out      (ser_out),
        .ser_out_valid(ser_out_valid),
        .count_out    (count_out),
        .ch_out       (ch_out),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] valid;
        logic [3:0] sout;
        logic [3:0] count;
        logic [1:0] ch;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        exp_t  e;
        string tag;
    } sb_t;

    typedef struct {
        logic en;
        logic sin;
        exp_t e;
    } vec_t;

    typedef struct {
        logic [1:0]  ch;
        logic [3:0]  len;
        logic [14:0] pay;
        int unsigned period;
        int unsigned gap;
        string       tag;
    } frame_t;

    sb_t        sb[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [1:0] model_ch;

    function automatic exp_t mk(input logic [3:0] valid, input logic [3:0] sout,
                                input logic [3:0] count, input logic [1:0] ch,
                                input logic busy_e, input logic done_e);
        exp_t e;
        e.valid = valid;
        e.sout  = sout;
        e.count = count;
        e.ch    = ch;
        e.busy  = busy_e;
        e.done  = done_e;
        return e;
    endfunction

    task automatic check(input exp_t e, input string tag);
        exp_t got;
        got = mk(ser_out_valid, ser_out, count_out, ch_out, busy, done);
        n_total++;
        if (got === e) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got valid=%b sout=%b count=%0d ch=%0d busy=%b done=%b, want valid=%b sout=%b count=%0d ch=%0d busy=%b done=%b",
                     tag, $time, got.valid, got.sout, got.count, got.ch, got.busy, got.done,
                     e.valid, e.sout, e.count, e.ch, e.busy, e.done);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t r;
            r = sb.pop_front();
            check(r.e, r.tag);
        end
    end

    task automatic apply(input logic en, input logic sin, input exp_t e, input string tag);
        sb_t r;
        @(posedge clk);
        #1;
        clk_en = en;
        ser_in = sin;
        r.e    = e;
        r.tag  = tag;
        sb.push_back(r);
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            apply(1'($urandom), 1'b1, mk(4'h0, 4'h0, 4'h0, model_ch, 1'b0, 1'b0), "idle");
        end
    endtask

    // Frame-level model: step k is the start bit (0), address (1..2), length (3..6)
    // or payload bit k-7; each step lasts `period` cycles with clk_en on the last.
    task automatic send_frame(input logic [1:0] ch, input logic [3:0] len,
                              input logic [14:0] pay, input int unsigned period,
                              input int unsigned stop, input string tag);
        int unsigned steps;
        steps = 7 + int'(len);
        for (int unsigned k = 0; k < steps && k < stop; k++) begin
            logic b;
            if (k == 0)      b = 1'b0;
            else if (k <= 2) b = ch[2 - k];
            else if (k <= 6) b = len[6 - k];
            else             b = pay[k - 7];
            if (k == 3) model_ch = ch;
            for (int unsigned c = 0; c < period; c++) begin
                logic en;
                logic sin;
                exp_t e;
                en  = (c == period - 1);
                sin = en ? b : 1'($urandom);
                if (k == 0)
                    e = mk(4'h0, 4'h0, 4'h0, model_ch, 1'b0, 1'b0);
                else if (k < 7)
                    e = mk(4'h0, 4'h0, 4'h0, model_ch, 1'b1, 1'b0);
                else
                    e = mk(4'(1 << ch), sin ? 4'(1 << ch) : 4'h0,
                           4'(int'(len) - int'(k - 7)), ch, 1'b1, 1'b0);
                apply(en, sin, e, tag);
            end
        end
        if (stop > steps) begin
            apply(1'($urandom), 1'($urandom), mk(4'h0, 4'h0, 4'h0, ch, 1'b1, 1'b1), tag);
        end
    endtask

    vec_t   v1[12];
    frame_t frames[7];

    initial begin
        // Hand-derived trace: start, ch=2 (10), len=3 (0011), payload 1,0,1.
        v1[0]  = '{en: 1'b1, sin: 1'b0, e: mk(4'h0, 4'h0, 4'd0, 2'd0, 1'b0, 1'b0)};
        v1[1]  = '{en: 1'b1, sin: 1'b1, e: mk(4'h0, 4'h0, 4'd0, 2'd0, 1'b1, 1'b0)};
        v1[2]  = '{en: 1'b1, sin: 1'b0, e: mk(4'h0, 4'h0, 4'd0, 2'd0, 1'b1, 1'b0)};
        v1[3]  = '{en: 1'b1, sin: 1'b0, e: mk(4'h0, 4'h0, 4'd0, 2'd2, 1'b1, 1'b0)};
        v1[4]  = '{en: 1'b1, sin: 1'b0, e: mk(4'h0, 4'h0, 4'd0, 2'd2, 1'b1, 1'b0)};
        v1[5]  = '{en: 1'b1, sin: 1'b1, e: mk(4'h0, 4'h0, 4'd0, 2'd2, 1'b1, 1'b0)};
        v1[6]  = '{en: 1'b1, sin: 1'b1, e: mk(4'h0, 4'h0, 4'd0, 2'd2, 1'b1, 1'b0)};
        v1[7]  = '{en: 1'b1, sin: 1'b1, e: mk(4'b0100, 4'b0100, 4'd3, 2'd2, 1'b1, 1'b0)};
        v1[8]  = '{en: 1'b1, sin: 1'b0, e: mk(4'b0100, 4'b0000, 4'd2, 2'd2, 1'b1, 1'b0)};
        v1[9]  = '{en: 1'b1, sin: 1'b1, e: mk(4'b0100, 4'b0100, 4'd1, 2'd2, 1'b1, 1'b0)};
        v1[10] = '{en: 1'b1, sin: 1'b1, e: mk(4'h0, 4'h0, 4'd0, 2'd2, 1'b1, 1'b1)};
        v1[11] = '{en: 1'b1, sin: 1'b1, e: mk(4'h0, 4'h0, 4'd0, 2'd2, 1'b0, 1'b0)};

        frames[0] = '{ch: 2'd1, len: 4'd0,  pay: 15'h0000, period: 1, gap: 2, tag: "zero_len"};
        frames[1] = '{ch: 2'd3, len: 4'd2,  pay: 15'b10,   period: 1, gap: 2, tag: "dense_ch3"};
        frames[2] = '{ch: 2'd3, len: 4'd2,  pay: 15'b10,   period: 4, gap: 3, tag: "sparse_ch3"};
        frames[3] = '{ch: 2'd0, len: 4'd1,  pay: 15'b1,    period: 1, gap: 0, tag: "b2b_first"};
        frames[4] = '{ch: 2'd3, len: 4'd2,  pay: 15'b01,   period: 1, gap: 2, tag: "b2b_second"};
        frames[5] = '{ch: 2'd1, len: 4'd15, pay: 15'h2D6B, period: 1, gap: 2, tag: "max_len"};
        frames[6] = '{ch: 2'd2, len: 4'd3,  pay: 15'b101,  period: 3, gap: 1, tag: "sparse_ch2"};

        rst      = 1'b0;
        clk_en   = 1'b0;
        ser_in   = 1'b1;
        model_ch = 2'd0;
        #1;
        check(mk(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0), "reset_state");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        idle_cycles(3);

        for (int unsigned i = 0; i < 12; i++) begin
            apply(v1[i].en, v1[i].sin, v1[i].e, "basic_ch2_len3");
        end
        model_ch = 2'd2;
        idle_cycles(2);

        foreach (frames[i]) begin
            send_frame(frames[i].ch, frames[i].len, frames[i].pay, frames[i].period, 100,
                       frames[i].tag);
            idle_cycles(frames[i].gap);
        end

        // Abort a len=5 frame on ch=2 after two payload bits have been consumed.
        send_frame(2'd2, 4'd5, 15'b10110, 1, 9, "pre_reset");
        @(posedge clk);
        #2;
        ser_in = 1'b1;
        #1;
        check(mk(4'b0100, 4'b0100, 4'd3, 2'd2, 1'b1, 1'b0), "mid_data_before_reset");
        rst = 1'b0;
        #1;
        check(mk(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0), "async_reset_mid_data");
        model_ch = 2'd0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check(mk(4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0), "after_reset_release");
        idle_cycles(3);
        send_frame(2'd1, 4'd1, 15'b1, 1, 100, "post_reset_frame");
        idle_cycles(3);

        repeat (2) @(negedge clk);
        n_total++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

endmodule
